xrv_fetch_aligner: RTL

Instruction-stream producer feeding the RV instruction decoder's insn_* inputs. Accepts 32-bit, halfword-addressed fetch words from the I-fetch path and aligns mixed RV32/RVC streams, including 32-bit instructions that straddle word boundaries. Emits at most one instruction per cycle, with PC, thread id, is_rv16 and illegal flags, through a registered valid/ready output. It sits between the fetch unit / I-cache response and the decode stage.

---
 rtl/xrv_fetch_aligner.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/xrv_fetch_aligner.sv
// xrv_fetch_aligner: turns halfword-addressed 32-bit fetch words into an
// aligned stream of RV32/RVC instructions for the decode stage. A 16-bit hold
// register carries the leftover upper halfword between words, so 32-bit
// instructions that straddle a word boundary are rebuilt. The output is a
// registered valid/ready stage that emits at most one instruction per cycle.
module xrv_fetch_aligner #(
   parameter  int NUM_TW_P      = 8,
   localparam int twid_width_lp = $clog2(NUM_TW_P)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     fetch_vld_i,
   output logic                     fetch_rdy_o,
   input  logic [31:0]              fetch_data_i,
   input  logic [31:0]              fetch_pc_i,
   input  logic [twid_width_lp-1:0] fetch_twid_i,
   input  logic                     fetch_err_i,
   output logic                     insn_vld_o,
   input  logic                     insn_rdy_i,
   output logic [31:0]              insn_o,
   output logic [31:0]              insn_pc_o,
   output logic [twid_width_lp-1:0] insn_twid_o,
   output logic                     insn_is_rv16_o,
   output logic                     insn_illegal_o
);

   typedef enum logic {RUN = 1'b0, ERR = 1'b1} state_e;

   // A halfword starts a compressed instruction unless its low bits are 2'b11.
   function automatic logic is_rvc(input logic [15:0] half);
      return half[1:0] != 2'b11;
   endfunction

   state_e                   state;
   logic                     hold_vld;
   logic [15:0]              hold_data;
   logic [31:0]              hold_pc;
   logic [twid_width_lp-1:0] hold_twid;

   logic                     out_free;
   logic                     hold_rvc;
   logic                     accept;

   logic                     emit;
   logic [31:0]              nxt_insn;
   logic [31:0]              nxt_pc;
   logic [twid_width_lp-1:0] nxt_twid;
   logic                     nxt_rv16;
   logic                     nxt_ill;
   logic                     hold_load;
   logic                     hold_clear;
   logic [15:0]              nxt_hdata;
   logic [31:0]              nxt_hpc;
   logic                     to_err;

   // Handshake: a pending RVC in hold is drained before any new word is taken.
   always_comb begin
      out_free = !insn_vld_o || insn_rdy_i;
      hold_rvc = hold_vld && is_rvc(hold_data);
      if (state == ERR) fetch_rdy_o = !flush_i;
      else              fetch_rdy_o = out_free && !flush_i && !hold_rvc;
      accept = fetch_vld_i && fetch_rdy_o;
   end

   // Alignment decode: choose the instruction to emit and the next hold contents.
   always_comb begin
      emit       = 1'b0;
      nxt_insn   = fetch_data_i;
      nxt_pc     = fetch_pc_i;
      nxt_twid   = fetch_twid_i;
      nxt_rv16   = 1'b0;
      nxt_ill    = 1'b0;
      hold_load  = 1'b0;
      hold_clear = 1'b0;
      nxt_hdata  = fetch_data_i[31:16];
      nxt_hpc    = fetch_pc_i + 32'd2;
      to_err     = 1'b0;
      if (state == RUN && out_free) begin
         if (hold_rvc) begin
            emit       = 1'b1;
            nxt_insn   = {16'h0000, hold_data};
            nxt_pc     = hold_pc;
            nxt_twid   = hold_twid;
            nxt_rv16   = 1'b1;
            hold_clear = 1'b1;
         end else if (accept) begin
            if (fetch_err_i) begin
               // Fault is charged to the oldest pending halfword if there is one.
               emit       = 1'b1;
               nxt_insn   = 32'h0000_0000;
               nxt_ill    = 1'b1;
               nxt_pc     = hold_vld ? hold_pc : fetch_pc_i;
               nxt_twid   = hold_vld ? hold_twid : fetch_twid_i;
               hold_clear = 1'b1;
               to_err     = 1'b1;
            end else if (hold_vld) begin
               emit      = 1'b1;
               nxt_insn  = {fetch_data_i[15:0], hold_data};
               nxt_pc    = hold_pc;
               nxt_twid  = hold_twid;
               hold_load = 1'b1;
            end else if (!fetch_pc_i[1]) begin
               emit = 1'b1;
               if (is_rvc(fetch_data_i[15:0])) begin
                  nxt_insn  = {16'h0000, fetch_data_i[15:0]};
                  nxt_rv16  = 1'b1;
                  hold_load = 1'b1;
               end
            end else if (is_rvc(fetch_data_i[31:16])) begin
               emit     = 1'b1;
               nxt_insn = {16'h0000, fetch_data_i[31:16]};
               nxt_rv16 = 1'b1;
            end else begin
               // Entry on the upper halfword of a 32-bit instruction: park it.
               hold_load = 1'b1;
               nxt_hpc   = fetch_pc_i;
            end
         end
      end
   end

   // Control state, hold valid and the registered output stage.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state          <= RUN;
         hold_vld       <= 1'b0;
         insn_vld_o     <= 1'b0;
         insn_o         <= '0;
         insn_pc_o      <= '0;
         insn_twid_o    <= '0;
         insn_is_rv16_o <= 1'b0;
         insn_illegal_o <= 1'b0;
      end else if (flush_i) begin
         state      <= RUN;
         hold_vld   <= 1'b0;
         insn_vld_o <= 1'b0;
      end else begin
         if (out_free) insn_vld_o <= emit;
         if (emit) begin
            insn_o         <= nxt_insn;
            insn_pc_o      <= nxt_pc;
            insn_twid_o    <= nxt_twid;
            insn_is_rv16_o <= nxt_rv16;
            insn_illegal_o <= nxt_ill;
         end
         if (hold_clear)     hold_vld <= 1'b0;
         else if (hold_load) hold_vld <= 1'b1;
         if (to_err) state <= ERR;
      end
   end

   // Hold payload: only meaningful while hold_vld is set, so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (hold_load && !flush_i && !hold_clear) begin
         hold_data <= nxt_hdata;
         hold_pc   <= nxt_hpc;
         hold_twid <= fetch_twid_i;
      end
   end

endmodule
